out_port_rr_arbiter: RTL and testbench

- Per-output-port switch allocator for the 5-port (L, W, N, E, S) multicast router.
- Shares one output channel among up to five routed input streams using round-robin priority.
- Registers the winning flit onto the output link and honours the downstream full signal.
- Five instances, one per output direction, replace the monolithic arbitration stage.

---
 rtl/out_port_rr_arbiter.sv | 135 +++++++++++++
 tb/tb_out_port_rr_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/out_port_rr_arbiter.sv
// Round-robin output-port allocator for the 5-port router: grants one requester per cycle into a registered output slot.
// Optional statistics counters are enabled with `define ARB_STATS_EN.
//
// state   | meaning
// --------+-----------------------------------------------
// S_EMPTY | output register holds no flit, valid_out=0
// S_BUSY  | output register holds a flit, valid_out=1
module out_port_rr_arbiter #(
  parameter int DATASIZE = 30,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4:0]            req,
  input  logic [5*DATASIZE-1:0] data_in,
  input  logic                  full_in,
  output logic [4:0]            grant,
  output logic                  valid_out,
  output logic [DATASIZE-1:0]   data_out,
  output logic [5*CNT_W-1:0]    grant_cnt,
  output logic [CNT_W-1:0]      stall_cnt
);

  typedef enum logic {S_EMPTY = 1'b0, S_BUSY = 1'b1} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2:0]          r_ptr;
  logic [2:0]          w_ptr_nxt;
  logic [DATASIZE-1:0] r_data;
  logic                w_can_accept;
  logic                w_gnt_any;
  logic [2:0]          w_gnt_idx;
  logic [2:0]          w_cand;
  logic [4:0]          w_grant;
  logic [DATASIZE-1:0] w_gnt_data;

  // (a + b) mod 5 for a, b in 0..4 without widening past 3 bits
  function automatic logic [2:0] mod5_add(input logic [2:0] a, input logic [2:0] b);
    logic [2:0] gap;
    gap = 3'd5 - b;
    if (a >= gap) return a - gap;
    else          return a + b;
  endfunction

  assign w_can_accept = (r_state == S_EMPTY) | ((r_state == S_BUSY) & ~full_in);

  // Scan from farthest to nearest so the nearest requester at/after ptr is left standing
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = 3'd0;
    w_cand    = 3'd0;
    for (int k = 4; k >= 0; k--) begin
      w_cand = mod5_add(r_ptr, 3'(k));
      if (req[w_cand]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
    if (!w_can_accept) w_gnt_any = 1'b0;
  end

  always_comb begin
    w_grant    = '0;
    w_gnt_data = '0;
    for (int i = 0; i < 5; i++) begin
      if (w_gnt_any && (w_gnt_idx == 3'(i))) begin
        w_grant[i] = 1'b1;
        w_gnt_data = data_in[i*DATASIZE +: DATASIZE];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      S_EMPTY: if (w_gnt_any) w_state_nxt = S_BUSY;
      S_BUSY: begin
        if (w_gnt_any)     w_state_nxt = S_BUSY;
        else if (!full_in) w_state_nxt = S_EMPTY;
      end
      default: w_state_nxt = S_EMPTY;
    endcase
    if (w_gnt_any) w_ptr_nxt = (w_gnt_idx == 3'd4) ? 3'd0 : w_gnt_idx + 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
      r_ptr   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // data_out keeps its last flit after draining; only a grant reloads it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_data <= '0;
    else if (w_gnt_any) r_data <= w_gnt_data;
  end

  assign grant     = w_grant;
  assign valid_out = (r_state == S_BUSY);
  assign data_out  = r_data;

`ifdef ARB_STATS_EN
  logic [CNT_W-1:0] r_grant_cnt [5];
  logic [CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) r_grant_cnt[i] <= '0;
      r_stall_cnt <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (w_grant[i] && (r_grant_cnt[i] != '1)) r_grant_cnt[i] <= r_grant_cnt[i] + 1'b1;
      end
      if ((r_state == S_BUSY) && full_in && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < 5; i++) grant_cnt[i*CNT_W +: CNT_W] = r_grant_cnt[i];
  end
  assign stall_cnt = r_stall_cnt;
`else
  assign grant_cnt = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_out_port_rr_arbiter.sv
// Directed bench for out_port_rr_arbiter: reset, single grant, round-robin rotation, wrap, stall and async reset.
module tb_out_port_rr_arbiter;
  localparam int DW = 30;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [4:0]      req;
  logic [5*DW-1:0] data_in;
  logic            full_in;
  logic [4:0]      grant;
  logic            valid_out;
  logic [DW-1:0]   data_out;
  logic [5*CW-1:0] grant_cnt;
  logic [CW-1:0]   stall_cnt;

  logic [DW-1:0] dval [5];
  logic [CW-1:0] exp_stall;
  int errors = 0;
  int checks = 0;

  out_port_rr_arbiter #(.DATASIZE(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in), .full_in(full_in),
    .grant(grant), .valid_out(valid_out), .data_out(data_out),
    .grant_cnt(grant_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; full_in = 1'b0;
    #1;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid_out); end
    checks++; if (data_out !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", data_out); end
    checks++; if (grant !== 5'b0) begin errors++; $display("FAIL reset_grant got %b exp 00000", grant); end
    checks++; if (grant_cnt !== '0 || stall_cnt !== '0) begin errors++; $display("FAIL reset_cnt got %h/%h exp 0", grant_cnt, stall_cnt); end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (valid_out !== 1'b0 || grant !== 5'b0 || data_out !== '0) begin
        errors++; $display("FAIL idle_c%0d got v=%b g=%b d=%h exp 0/00000/0", c, valid_out, grant, data_out);
      end
    end
  endtask

  task automatic test_single();
    req = 5'b00100;
    #1;
    checks++; if (grant !== 5'b00100) begin errors++; $display("FAIL single_grant got %b exp 00100", grant); end
    tick();
    req = '0;
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", valid_out); end
    checks++; if (data_out !== 30'h1234567) begin errors++; $display("FAIL single_data got %h exp 1234567", data_out); end
    #1;
    checks++; if (grant !== 5'b0) begin errors++; $display("FAIL single_nogrant got %b exp 00000", grant); end
    tick();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL single_drain got %b exp 0", valid_out); end
    checks++; if (data_out !== 30'h1234567) begin errors++; $display("FAIL single_retain got %h exp 1234567", data_out); end
  endtask

  task automatic test_all_five();
    logic [4:0] exp_g;
    pulse_reset();
    req = 5'b11111;
    for (int c = 0; c < 7; c++) begin
      #1;
      exp_g = 5'b00001 << (c % 5);
      checks++; if (grant !== exp_g) begin errors++; $display("FAIL rr_grant_c%0d got %b exp %b", c, grant, exp_g); end
      tick();
      checks++;
      if (valid_out !== 1'b1 || data_out !== dval[c % 5]) begin
        errors++; $display("FAIL rr_out_c%0d got v=%b d=%h exp 1/%h", c, valid_out, data_out, dval[c % 5]);
      end
    end
    req = '0;
    tick();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rr_drain got %b exp 0", valid_out); end
  endtask

  // ptr=2 on entry (last grant was W)
  task automatic test_wrap();
    req = 5'b10010;
    #1;
    checks++; if (grant !== 5'b10000) begin errors++; $display("FAIL wrap_first got %b exp 10000", grant); end
    tick();
    req = 5'b00010;
    #1;
    checks++; if (grant !== 5'b00010) begin errors++; $display("FAIL wrap_second got %b exp 00010", grant); end
    checks++; if (data_out !== dval[4]) begin errors++; $display("FAIL wrap_dataS got %h exp %h", data_out, dval[4]); end
    tick();
    req = '0;
    checks++; if (data_out !== dval[1]) begin errors++; $display("FAIL wrap_dataW got %h exp %h", data_out, dval[1]); end
    req = 5'b00111;
    #1;
    checks++; if (grant !== 5'b00100) begin errors++; $display("FAIL wrap_ptr2 got %b exp 00100", grant); end
    tick();
    req = '0;
    checks++; if (data_out !== dval[2]) begin errors++; $display("FAIL wrap_dataN got %h exp %h", data_out, dval[2]); end
    tick();
  endtask

  // ptr=3 on entry
  task automatic test_full_stall();
    req = 5'b00100;
    #1;
    checks++; if (grant !== 5'b00100) begin errors++; $display("FAIL stall_load got %b exp 00100", grant); end
    tick();
    req = 5'b00001;
    full_in = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (grant !== 5'b0 || valid_out !== 1'b1 || data_out !== dval[2]) begin
        errors++; $display("FAIL stall_hold_c%0d got g=%b v=%b d=%h exp 00000/1/%h", c, grant, valid_out, data_out, dval[2]);
      end
      tick();
    end
    full_in = 1'b0;
    #1;
    checks++; if (grant !== 5'b00001) begin errors++; $display("FAIL stall_release got %b exp 00001", grant); end
`ifdef ARB_STATS_EN
    exp_stall = CW'(3);
`else
    exp_stall = '0;
`endif
    checks++; if (stall_cnt !== exp_stall) begin errors++; $display("FAIL stall_cnt got %0d exp %0d", stall_cnt, exp_stall); end
    tick();
    req = '0;
    checks++;
    if (valid_out !== 1'b1 || data_out !== dval[0]) begin
      errors++; $display("FAIL stall_dataL got v=%b d=%h exp 1/%h", valid_out, data_out, dval[0]);
    end
    tick();
  endtask

  // ptr=1 on entry
  task automatic test_reset_busy();
    req = 5'b00010;
    tick();
    req = '0;
    full_in = 1'b1;
    #1;
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL rb_busy got %b exp 1", valid_out); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (valid_out !== 1'b0 || data_out !== '0) begin
      errors++; $display("FAIL rb_async got v=%b d=%h exp 0/0", valid_out, data_out);
    end
    rst_n = 1'b1;
    full_in = 1'b0;
    req = 5'b11111;
    #1;
    checks++; if (grant !== 5'b00001) begin errors++; $display("FAIL rb_first got %b exp 00001", grant); end
    tick();
    req = '0;
    checks++; if (data_out !== dval[0]) begin errors++; $display("FAIL rb_data got %h exp %h", data_out, dval[0]); end
    tick();
  endtask

  initial begin
    dval[0] = 30'h0000011; dval[1] = 30'h2A00022; dval[2] = 30'h1234567;
    dval[3] = 30'h3C00044; dval[4] = 30'h0500055;
    for (int i = 0; i < 5; i++) data_in[i*DW +: DW] = dval[i];
    exp_stall = '0;
    test_reset();
    test_single();
    test_all_five();
    test_wrap();
    test_full_stall();
    test_reset_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
